// File: rtl/imem_fetch_port.sv
// imem_fetch_port: byte-addressed instruction memory with a valid/ready fetch port,
// registered read stage, 2-entry response queue, flush and run-time program load.
`default_nettype none

module imem_fetch_port #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_pc,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_W-1:0]        resp_instr,
  output logic [ADDR_W-1:0]        resp_pc,
  output logic [1:0]               resp_fault
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        fault;
  } entry_t;

  logic [DATA_W-1:0] mem [DEPTH];

  entry_t      stage_q, stage_d;
  logic        inflight_q, inflight_d;
  entry_t      fifo_q [2];
  entry_t      fifo_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;

  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  rd_idx;
  logic              misaligned;
  logic              out_of_range;
  logic [2:0]        credits;
  logic              accept;
  logic              push;
  logic              pop;
  entry_t            head;

  // Contents are deliberately not reset; only the loader defines them.
  always_ff @(posedge clk) begin
    if (load_en && ({1'b0, load_addr} < (IDX_W+1)'(DEPTH))) begin
      mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    word_addr    = req_pc >> 2;
    rd_idx       = req_pc[IDX_W+1:2];
    misaligned   = |req_pc[1:0];
    out_of_range = (word_addr >= ADDR_W'(DEPTH));

    credits   = {1'b0, count_q} + {2'b00, inflight_q};
    req_ready = !load_en && !flush && (credits < 3'd2);
    accept    = req_valid && req_ready;
    push      = inflight_q;
    pop       = (count_q != 2'd0) && resp_ready;

    stage_d = stage_q;
    if (accept) begin
      stage_d.pc    = req_pc;
      stage_d.fault = {out_of_range, misaligned};
      stage_d.instr = (misaligned || out_of_range) ? NOP_INSTR : mem[rd_idx];
    end
    inflight_d = accept;

    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // Flush drops the stage register and the queue, including any same-cycle push/pop.
    if (flush) begin
      inflight_d = 1'b0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      count_d    = 2'd0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = stage_q;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q    <= '0;
      inflight_q <= 1'b0;
      fifo_q     <= '{default: '0};
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      stage_q    <= stage_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    head       = fifo_q[rd_ptr_q];
    resp_valid = (count_q != 2'd0);
    resp_instr = resp_valid ? head.instr : NOP_INSTR;
    resp_pc    = resp_valid ? head.pc    : '0;
    resp_fault = resp_valid ? head.fault : 2'b00;
  end

endmodule

`default_nettype wire
